// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory, redirect and decode-side signals of the fetch unit
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_ins;
  logic [31:0] if_pc4;

  modport master (
    output imem_req, imem_addr, if_valid, if_ins, if_pc4,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_stall
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_ins, if_pc4,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_stall
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with a one-entry output buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_ins_q, if_ins_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        req;
  logic        handshake;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_ins_d   = if_ins_q;
    if_pc4_d   = if_pc4_q;
    req        = (state_q == REQ) && (!if_valid_q || !bus.id_stall);
    handshake  = req && bus.imem_gnt;

    if (if_valid_q && !bus.id_stall) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (handshake) begin
          pc_d    = pc_q + 32'd4;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // pc_q already advanced past the granted address, so it is that address plus 4
        if (bus.imem_rvalid) begin
          if_valid_d = 1'b1;
          if_ins_d   = bus.imem_rdata;
          if_pc4_d   = pc_q;
          state_d    = REQ;
        end
      end
      FLUSH: begin
        if (bus.imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.redirect) begin
      pc_d       = bus.redirect_pc & ~32'h3;
      if_valid_d = 1'b0;
      if_ins_d   = if_ins_q;
      if_pc4_d   = if_pc4_q;
      unique case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = handshake ? FLUSH : REQ;
        WAIT:    state_d = bus.imem_rvalid ? REQ : FLUSH;
        FLUSH:   state_d = bus.imem_rvalid ? REQ : FLUSH;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_ins_q   <= 32'h0;
      if_pc4_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_ins_q   <= if_ins_d;
      if_pc4_q   <= if_pc4_d;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_ins    = if_ins_q;
  assign bus.if_pc4    = if_pc4_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed checks of fetch_unit against a transaction model
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] exp_addr, out_addr, m_ins, m_pc4;
  bit          out_valid, out_killed, m_valid;
  int          out_lat, min_lat, max_lat;
  logic [31:0] gq[$];
  logic [31:0] pq[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  task automatic model_reset();
    exp_addr   = RST_PC;
    out_valid  = 0;
    out_killed = 0;
    out_lat    = 0;
    m_valid    = 0;
    m_ins      = 32'h0;
    m_pc4      = 32'h0;
    gq.delete();
    pq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.id_stall = 1'b0;
    #1;
    n_chk++;
    if ({bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_ins, bus.if_pc4} !==
        {1'b0, RST_PC, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b addr=%h v=%b ins=%h pc4=%h expected 0 %h 0 0 0",
               bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_ins, bus.if_pc4, RST_PC);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: got %b expected 0", bus.imem_req);
    end
  endtask

  // One clock of stimulus: drive at negedge, check, then advance the transaction model
  task automatic step(input bit stall, input bit redir, input logic [31:0] rpc,
                      input bit gnt, input bit spurious);
    bit          rv, hs, exp_req, deliver, cons;
    logic [31:0] dv_addr;
    @(negedge clk);
    rv = out_valid && (out_lat == 0);
    dv_addr = out_addr;
    bus.id_stall    = stall;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv || (spurious && !out_valid);
    bus.imem_rdata  = rv ? mem_word(out_addr) : $urandom;
    #1;
    n_chk++;
    if (bus.if_valid !== m_valid) begin
      n_fail++;
      $display("FAIL if_valid: got %b expected %b", bus.if_valid, m_valid);
    end
    if (m_valid) begin
      n_chk++;
      if ({bus.if_ins, bus.if_pc4} !== {m_ins, m_pc4}) begin
        n_fail++;
        $display("FAIL if_data: got ins=%h pc4=%h expected ins=%h pc4=%h",
                 bus.if_ins, bus.if_pc4, m_ins, m_pc4);
      end
    end
    exp_req = !out_valid && !(m_valid && stall);
    n_chk++;
    if (bus.imem_req !== exp_req) begin
      n_fail++;
      $display("FAIL imem_req: got %b expected %b", bus.imem_req, exp_req);
    end
    hs = (bus.imem_req === 1'b1) && gnt;
    if (hs) begin
      n_chk++;
      if (bus.imem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL imem_addr: got %h expected %h", bus.imem_addr, exp_addr);
      end
    end

    cons = m_valid && !stall;
    deliver = 0;
    if (rv) begin
      deliver = !out_killed && !redir;
      out_valid = 0;
    end else if (out_valid) begin
      out_lat--;
    end
    if (hs) begin
      out_valid  = 1;
      out_addr   = exp_addr;
      out_killed = 0;
      out_lat    = int'($urandom_range(max_lat, min_lat));
      gq.push_back(exp_addr);
      exp_addr = exp_addr + 32'd4;
    end
    if (redir) begin
      m_valid  = 0;
      exp_addr = rpc & ~32'h3;
      if (out_valid) out_killed = 1;
    end else if (deliver) begin
      m_valid = 1;
      m_ins   = mem_word(dv_addr);
      m_pc4   = dv_addr + 32'd4;
      pq.push_back(m_pc4);
    end else if (cons) begin
      m_valid = 0;
    end
  endtask

  task automatic run_until_grants(input int n, input string name);
    int k = 0;
    while (gq.size() < n && k < 40) begin
      step(0, 0, 32'h0, 1, 0);
      k++;
    end
    if (gq.size() < n) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got %0d grants expected %0d", name, gq.size(), n);
    end
  endtask

  task automatic run_until_deliveries(input int n, input string name);
    int k = 0;
    while (pq.size() < n && k < 40) begin
      step(0, 0, 32'h0, 1, 0);
      k++;
    end
    if (pq.size() < n) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got %0d deliveries expected %0d", name, pq.size(), n);
    end
  endtask

  task automatic test_reset();
    min_lat = 0; max_lat = 0;
    do_reset();
    step(0, 0, 32'h0, 1, 0);
    n_chk++;
    if (gq.size() != 1 || gq[0] !== RST_PC) begin
      n_fail++;
      $display("FAIL first_fetch: got %0d grants expected one at %h", gq.size(), RST_PC);
    end
  endtask

  task automatic test_sequential();
    min_lat = 0; max_lat = 0;
    do_reset();
    run_until_deliveries(3, "seq");
    n_chk++;
    if (gq.size() < 3 || {gq[0], gq[1], gq[2]} !== {32'h3000, 32'h3004, 32'h3008}) begin
      n_fail++;
      $display("FAIL seq_addrs: got %0d grants expected 3000 3004 3008", gq.size());
    end
    n_chk++;
    if (pq.size() < 3 || {pq[0], pq[1], pq[2]} !== {32'h3004, 32'h3008, 32'h300C}) begin
      n_fail++;
      $display("FAIL seq_pc4: got %0d deliveries expected 3004 3008 300C", pq.size());
    end
  endtask

  task automatic test_stall();
    int          k = 0;
    logic [31:0] held_ins, held_pc4;
    min_lat = 1; max_lat = 1;
    do_reset();
    while (!m_valid && k < 20) begin
      step(1, 0, 32'h0, 1, 0);
      k++;
    end
    held_ins = m_ins;
    held_pc4 = m_pc4;
    repeat (5) step(1, 0, 32'h0, 1, 0);
    n_chk++;
    if ({bus.if_valid, bus.if_ins, bus.if_pc4} !== {1'b1, held_ins, held_pc4}) begin
      n_fail++;
      $display("FAIL stall_hold: got v=%b ins=%h pc4=%h expected 1 %h %h",
               bus.if_valid, bus.if_ins, bus.if_pc4, held_ins, held_pc4);
    end
    k = gq.size();
    step(0, 0, 32'h0, 1, 0);
    n_chk++;
    if (gq.size() != k + 1 || gq[gq.size()-1] !== held_pc4) begin
      n_fail++;
      $display("FAIL stall_release: got %0d new grants expected one at %h", gq.size() - k, held_pc4);
    end
  endtask

  task automatic test_redirect_wait();
    int pre;
    min_lat = 2; max_lat = 2;
    do_reset();
    run_until_grants(3, "rw");
    pre = pq.size();
    step(0, 1, 32'h0000_4001, 1, 0);
    run_until_deliveries(pre + 1, "rw");
    n_chk++;
    if (gq.size() < 4 || gq[3] !== 32'h4000) begin
      n_fail++;
      $display("FAIL rw_addr: got %0d grants expected fourth at 00004000", gq.size());
    end
    n_chk++;
    if (pq.size() <= pre || pq[pre] !== 32'h4004) begin
      n_fail++;
      $display("FAIL rw_pc4: got %0d deliveries expected next pc4 00004004", pq.size());
    end
  endtask

  task automatic test_simultaneous();
    int k;
    min_lat = 0; max_lat = 0;
    do_reset();
    run_until_grants(1, "sim");
    step(0, 1, 32'h0000_5000, 1, 0);
    n_chk++;
    if (bus.if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_rv_valid: got %b expected 0", bus.if_valid);
    end
    step(0, 0, 32'h0, 1, 0);
    n_chk++;
    if (gq[gq.size()-1] !== 32'h5000) begin
      n_fail++;
      $display("FAIL sim_rv_addr: got %h expected 00005000", gq[gq.size()-1]);
    end
    step(0, 0, 32'h0, 1, 0);
    k = gq.size();
    step(0, 1, 32'h0000_5000, 1, 0);
    n_chk++;
    if (gq.size() != k + 1) begin
      n_fail++;
      $display("FAIL sim_gnt_hs: got %0d new grants expected 1", gq.size() - k);
    end
    run_until_grants(k + 2, "sim");
    n_chk++;
    if (gq[gq.size()-1] !== 32'h5000) begin
      n_fail++;
      $display("FAIL sim_gnt_addr: got %h expected 00005000", gq[gq.size()-1]);
    end
  endtask

  task automatic test_wrap();
    int g, p;
    min_lat = 0; max_lat = 1;
    do_reset();
    run_until_grants(1, "wrap");
    step(0, 1, 32'hFFFF_FFFE, 1, 0);
    g = gq.size();
    p = pq.size();
    run_until_grants(g + 2, "wrap");
    n_chk++;
    if (gq.size() < g + 2 || {gq[g], gq[g+1]} !== {32'hFFFF_FFFC, 32'h0000_0000}) begin
      n_fail++;
      $display("FAIL wrap_addr: got %0d grants expected FFFFFFFC then 00000000", gq.size() - g);
    end
    run_until_deliveries(p + 1, "wrap");
    n_chk++;
    if (pq.size() <= p || pq[p] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_pc4: got %0d deliveries expected pc4 00000000", pq.size() - p);
    end
  endtask

  task automatic test_reset_mid_wait();
    min_lat = 3; max_lat = 3;
    do_reset();
    run_until_grants(2, "rmw");
    step(0, 0, 32'h0, 1, 0);
    do_reset();
    step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 1, 1);
    n_chk++;
    if (gq.size() != 1 || gq[0] !== RST_PC) begin
      n_fail++;
      $display("FAIL rmw_first: got %0d grants expected one at %h", gq.size(), RST_PC);
    end
  endtask

  task automatic test_random();
    min_lat = 0; max_lat = 3;
    do_reset();
    repeat (600) begin
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, $urandom,
           $urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1);
    end
    n_chk++;
    if (gq.size() < 40) begin
      n_fail++;
      $display("FAIL rand_progress: got %0d grants expected at least 40", gq.size());
    end
  endtask

  initial begin
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.id_stall = 1'b0;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_simultaneous();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
